sequential_divider: RTL

//  Iterative signed restoring divider: the inverse of the shift-add signed multiplier.

---
 rtl/sequential_divider.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sequential_divider.sv
`default_nettype none
// ============================================================================
// Module      : sequential_divider
// Description : Iterative signed restoring divider. It produces one quotient
//               bit per clock, MSB first, behind a start/done handshake.
//               Both the quotient and the remainder truncate toward zero.
//               The remainder takes the sign of the dividend.
//               A zero divisor is flagged and bypasses the iteration.
// Ports       : clk          rising-edge clock
//               rst_n        asynchronous active-low reset
//               start        division request, sampled only while idle
//               dividend     signed dividend, captured on acceptance
//               divisor      signed divisor, captured on acceptance
//               busy         high from the cycle after acceptance to done
//               done         one-cycle pulse, results valid from here
//               quotient     signed quotient
//               remainder    signed remainder
//               div_by_zero  divisor was zero; held with the results
// Revision    : 1.0 - initial release
// ============================================================================
module sequential_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int                 c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;

    logic [1:0]         r_state;
    // Dividend magnitude. Quotient bits shift in at the LSB as dividend bits
    // leave at the MSB, so r_a ends up holding |quotient|.
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH:0]     r_b;      // |divisor|, one extra bit so |MIN| is exact
    logic [WIDTH-1:0]   r_rem;    // partial remainder, always < |divisor|
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_sq;     // quotient sign
    logic               r_sr;     // remainder sign (dividend sign)
    logic               r_dz;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic               w_dz;
    logic [WIDTH:0]     w_trial;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_neg_q;
    logic [WIDTH-1:0]   w_neg_r;

    // The negation of MIN wraps back to MIN. Read as unsigned, that value is
    // exactly |MIN|.
    assign w_abs_a = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    assign w_abs_b = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
    assign w_dz    = (divisor == '0);

    assign w_trial = {r_rem, r_a[WIDTH-1]};
    assign w_ge    = (w_trial >= r_b);
    // The true difference is below |divisor| and fits in WIDTH bits.
    // Modular subtraction of the low bits is therefore exact.
    assign w_diff  = w_trial[WIDTH-1:0] - r_b[WIDTH-1:0];

    assign w_neg_q = ~r_a + 1'b1;
    assign w_neg_r = ~r_rem + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_sq        <= 1'b0;
            r_sr        <= 1'b0;
            r_dz        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    // A start that arrives during the done cycle is dropped.
                    if (start && !done) begin
                        r_a   <= w_abs_a;
                        r_b   <= {1'b0, w_abs_b};
                        r_sq  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        r_sr  <= dividend[WIDTH-1];
                        r_dz  <= w_dz;
                        r_cnt <= c_CNT_LAST;
                        busy  <= 1'b1;
                        if (w_dz) begin
                            // Preload |dividend| so that the sign fix in FIX
                            // rebuilds the dividend as the remainder.
                            r_rem   <= w_abs_a;
                            r_state <= c_FIX;
                        end else begin
                            r_rem   <= '0;
                            r_state <= c_CALC;
                        end
                    end
                end
                c_CALC: begin
                    r_rem <= w_ge ? w_diff : w_trial[WIDTH-1:0];
                    r_a   <= {r_a[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state <= c_FIX;
                    end
                end
                c_FIX: begin
                    quotient    <= r_dz ? '1 : (r_sq ? w_neg_q : r_a);
                    remainder   <= r_sr ? w_neg_r : r_rem;
                    div_by_zero <= r_dz;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    r_state     <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
